// File: rtl/risc_ctrl_fsm.sv
// Eight-phase instruction sequencer for the 8-bit accumulator CPU.
// Phase, run and halted are the only state; every strobe is decoded
// combinationally from (phase, opcode, zero, run).
module risc_ctrl_fsm #(
    parameter bit HLT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       alu_ena,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t state_q;
    logic   run_q;
    logic   halted_q;
    logic   is_alu;
    logic   is_sto;
    logic   is_jmp;
    logic   is_skz;

    assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);
    assign is_skz = (opcode == OP_SKZ);

    assign phase = state_q;
    assign halt  = halted_q;

    // Phase sequencer with run/halt control. A HLT opcode latches halted at
    // the end of OP_ADDR and drops straight back to INST_ADDR, so OP_FETCH is
    // never entered with halted set and no strobe follows the halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INST_ADDR;
            run_q    <= 1'b0;
            halted_q <= 1'b0;
        end else if (!run_q) begin
            state_q <= INST_ADDR;
            if (halted_q) begin
                if (HLT_STICKY == 1'b0 && !ena)
                    halted_q <= 1'b0;
            end else if (ena) begin
                run_q <= 1'b1;
            end
        end else begin
            case (state_q)
                INST_ADDR:  state_q <= INST_FETCH;
                INST_FETCH: state_q <= INST_LOAD;
                INST_LOAD:  state_q <= IDLE;
                IDLE:       state_q <= OP_ADDR;
                OP_ADDR: begin
                    if (opcode == OP_HLT) begin
                        halted_q <= 1'b1;
                        run_q    <= 1'b0;
                        state_q  <= INST_ADDR;
                    end else begin
                        state_q  <= OP_FETCH;
                    end
                end
                OP_FETCH:   state_q <= ALU_OP;
                ALU_OP:     state_q <= STORE;
                // Only the instruction boundary may stop the sequencer.
                STORE: begin
                    state_q <= INST_ADDR;
                    if (!ena)
                        run_q <= 1'b0;
                end
                default:    state_q <= INST_ADDR;
            endcase
        end
    end

    // Strobe decode; everything is quiet while the sequencer is stopped.
    // JMP raises ld_pc and inc_pc together in STORE: the pc block gives
    // ld_pc priority, so the overlap is intentional.
    always_comb begin
        sel     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        ld_ir   = 1'b0;
        ld_ac   = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        alu_ena = 1'b0;
        data_e  = 1'b0;
        if (run_q) begin
            case (state_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                OP_FETCH: begin
                    rd = is_alu;
                end
                ALU_OP: begin
                    rd      = is_alu;
                    alu_ena = is_alu;
                    inc_pc  = is_skz && zero;
                    ld_pc   = is_jmp;
                    data_e  = is_sto;
                end
                STORE: begin
                    rd     = is_alu;
                    ld_ac  = is_alu;
                    inc_pc = is_jmp;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

endmodule
